// File: rtl/sram_pkg.sv
// Shared types for the SRAM decoder port scheduler: row address width,
// row address type and the scheduler FSM state encoding.
package sram_pkg;

  localparam int ADDR_W   = 7;
  localparam int NUM_ROWS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] row_addr_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    WR_PRIO = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sram_port_scheduler_rr_pick2.sv
// Round-robin picker: starting at ptr and wrapping modulo N, returns the first
// and second eligible requesters as one-hot picks plus their indices.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick1,
  output logic          v1,
  output logic [PW-1:0] idx1,
  output logic [N-1:0]  pick2,
  output logic          v2,
  output logic [PW-1:0] idx2
);

  int idx;

  always_comb begin
    pick1 = '0;
    v1    = 1'b0;
    idx1  = '0;
    pick2 = '0;
    v2    = 1'b0;
    idx2  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so a single subtraction performs the wrap.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (elig[idx]) begin
        if (!v1) begin
          v1         = 1'b1;
          idx1       = PW'(idx);
          pick1[idx] = 1'b1;
        end else if (!v2) begin
          v2         = 1'b1;
          idx2       = PW'(idx);
          pick2[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_scheduler.sv
// Arbitrates NUM_RD readers and one writer onto a 2-read/1-write row decoder,
// registering the decoder controls and tagging each read port with its source.
module sram_port_scheduler #(
  parameter int NUM_RD        = 4,
  parameter int ADDR_W        = 7,
  parameter int WR_STARVE_MAX = 3,
  localparam int PW           = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_gnt,
  output logic [ADDR_W-1:0]        read_address1,
  output logic                     read_enable1,
  output logic [PW-1:0]            read_src1,
  output logic [ADDR_W-1:0]        read_address2,
  output logic                     read_enable2,
  output logic [PW-1:0]            read_src2,
  output logic [ADDR_W-1:0]        write_address,
  output logic                     write_enable,
  output logic                     dbg_wr_prio,
  output logic [7:0]               dbg_starve_cnt
);

  import sram_pkg::*;

  // Handshake: a requester transfers in the cycle where req && gnt are both 1;
  // the decoder sees it in the following cycle only. Un-granted requesters hold
  // req and address stable; wr_req must stay high while in WR_PRIO.

  sched_state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    starve_cnt_q, starve_cnt_d;

  logic [ADDR_W-1:0] read_address1_q, read_address1_d;
  logic              read_enable1_q, read_enable1_d;
  logic [PW-1:0]     read_src1_q, read_src1_d;
  logic [ADDR_W-1:0] read_address2_q, read_address2_d;
  logic              read_enable2_q, read_enable2_d;
  logic [PW-1:0]     read_src2_q, read_src2_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic              write_enable_q, write_enable_d;

  logic [NUM_RD-1:0] hit, elig;
  logic [NUM_RD-1:0] pick1, pick2;
  logic              v1, v2, use1, use2;
  logic [PW-1:0]     idx1, idx2;
  logic [ADDR_W-1:0] a1, a2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    return (int'(i) == NUM_RD - 1) ? '0 : PW'(int'(i) + 1);
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      hit[i] = (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr);
    end
    elig = '0;
    if (rst_n) begin
      // In write-priority mode, readers of the row being written step aside.
      elig = (state_q == WR_PRIO) ? (rd_req & ~hit) : rd_req;
    end
  end

  rr_pick2 #(
    .N  (NUM_RD),
    .PW (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr_q),
    .pick1 (pick1),
    .v1    (v1),
    .idx1  (idx1),
    .pick2 (pick2),
    .v2    (v2),
    .idx2  (idx2)
  );

  assign a1 = rd_addr[int'(idx1)*ADDR_W +: ADDR_W];
  assign a2 = rd_addr[int'(idx2)*ADDR_W +: ADDR_W];

  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    rr_ptr_d        = rr_ptr_q;
    use1            = 1'b0;
    use2            = 1'b0;
    wr_gnt          = 1'b0;
    rd_gnt          = '0;
    read_address1_d = '0;
    read_enable1_d  = 1'b0;
    read_src1_d     = '0;
    read_address2_d = '0;
    read_enable2_d  = 1'b0;
    read_src2_d     = '0;
    write_address_d = '0;
    write_enable_d  = 1'b0;

    if (rst_n) begin
      case (state_q)
        NORMAL: begin
          use1   = v1;
          use2   = v2;
          // Two reads would make the decoder drop the write; a same-row read
          // would race it.
          wr_gnt = wr_req && !(v1 && v2) && !(v1 && (a1 == wr_addr));
          if (wr_gnt) begin
            starve_cnt_d = '0;
          end else if (wr_req) begin
            if (starve_cnt_q < 8'(WR_STARVE_MAX)) starve_cnt_d = starve_cnt_q + 8'd1;
            if (starve_cnt_d == 8'(WR_STARVE_MAX)) state_d = WR_PRIO;
          end
        end
        WR_PRIO: begin
          use1         = v1;
          wr_gnt       = 1'b1;
          state_d      = NORMAL;
          starve_cnt_d = '0;
        end
        default: state_d = NORMAL;
      endcase

      rd_gnt = (use1 ? pick1 : '0) | (use2 ? pick2 : '0);
      if (use2)      rr_ptr_d = ptr_inc(idx2);
      else if (use1) rr_ptr_d = ptr_inc(idx1);

      read_enable1_d  = use1;
      read_address1_d = use1 ? a1 : '0;
      read_src1_d     = use1 ? idx1 : '0;
      read_enable2_d  = use2;
      read_address2_d = use2 ? a2 : '0;
      read_src2_d     = use2 ? idx2 : '0;
      write_enable_d  = wr_req && wr_gnt;
      write_address_d = (wr_req && wr_gnt) ? wr_addr : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= NORMAL;
      starve_cnt_q    <= '0;
      rr_ptr_q        <= '0;
      read_address1_q <= '0;
      read_enable1_q  <= 1'b0;
      read_src1_q     <= '0;
      read_address2_q <= '0;
      read_enable2_q  <= 1'b0;
      read_src2_q     <= '0;
      write_address_q <= '0;
      write_enable_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_cnt_q    <= starve_cnt_d;
      rr_ptr_q        <= rr_ptr_d;
      read_address1_q <= read_address1_d;
      read_enable1_q  <= read_enable1_d;
      read_src1_q     <= read_src1_d;
      read_address2_q <= read_address2_d;
      read_enable2_q  <= read_enable2_d;
      read_src2_q     <= read_src2_d;
      write_address_q <= write_address_d;
      write_enable_q  <= write_enable_d;
    end
  end

  assign read_address1  = read_address1_q;
  assign read_enable1   = read_enable1_q;
  assign read_src1      = read_src1_q;
  assign read_address2  = read_address2_q;
  assign read_enable2   = read_enable2_q;
  assign read_src2      = read_src2_q;
  assign write_address  = write_address_q;
  assign write_enable   = write_enable_q;
  assign dbg_wr_prio    = (state_q == WR_PRIO);
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_sram_port_scheduler.sv
// Bench for sram_port_scheduler: directed vector table with a decoder-output
// scoreboard, followed by a constrained-random phase with protocol checks.
module tb_sram_port_scheduler;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic            wr_req;
  logic [AW-1:0]   wr_addr;
  logic            wr_gnt;
  logic [AW-1:0]   read_address1, read_address2, write_address;
  logic            read_enable1, read_enable2, write_enable;
  logic [PW-1:0]   read_src1, read_src2;
  logic            dbg_wr_prio;
  logic [7:0]      dbg_starve_cnt;

  always #5 clk = ~clk;

  sram_port_scheduler #(.NUM_RD(N), .ADDR_W(AW), .WR_STARVE_MAX(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_gnt         (wr_gnt),
    .read_address1  (read_address1),
    .read_enable1   (read_enable1),
    .read_src1      (read_src1),
    .read_address2  (read_address2),
    .read_enable2   (read_enable2),
    .read_src2      (read_src2),
    .write_address  (write_address),
    .write_enable   (write_enable),
    .dbg_wr_prio    (dbg_wr_prio),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  int tests = 0;
  int fails = 0;
  logic [27:0] exp_q[$];
  logic [27:0] got_dec;

  assign got_dec = {read_enable1, read_address1, read_src1,
                    read_enable2, read_address2, read_src2,
                    write_enable, write_address};

  typedef struct {
    logic        rst;
    logic [3:0]  rdq;
    logic [27:0] ra;
    logic        wq;
    logic [6:0]  wa;
    logic [3:0]  eg;
    logic        ewg;
    logic        est;
    logic [7:0]  ecnt;
    logic [27:0] edec;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [27:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  function automatic logic [27:0] dec(input int re1, input int ra1, input int rs1,
                                      input int re2, input int ra2, input int rs2,
                                      input int we, input int wa);
    return {1'(re1), 7'(ra1), 2'(rs1), 1'(re2), 7'(ra2), 2'(rs2), 1'(we), 7'(wa)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pop_dec(input int idx);
    logic [27:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("decoder_after_vec%0d", idx), {4'b0, got_dec}, {4'b0, e});
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [27:0] a,
                       input logic w, input logic [6:0] wa);
    rst_n   = r;
    rd_req  = q;
    rd_addr = a;
    wr_req  = w;
    wr_addr = wa;
  endtask

  // Writer must hold its request through a write-priority cycle.
  always @(negedge clk) begin
    if (rst_n && dbg_wr_prio) begin
      tests++;
      if (!wr_req) begin
        fails++;
        $display("FAIL wr_req_drop_in_prio: got 0 expected 1");
      end
    end
  end

  initial begin
    logic [27:0] a;
    logic [3:0]  rq, g;
    logic [27:0] ra;
    logic        wq, wg, conflict;
    logic [6:0]  wa;
    int          refused;

    drive(1'b0, 4'b0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;

    a = pk(10, 11, 12, 13);
    //          rst   rdq      ra              wq    wa     eg       ewg   est   ecnt   edec
    vecs[0]  = '{1'b0, 4'b1111, a,              1'b1, 7'd20, 4'b0000, 1'b0, 1'b0, 8'd0, dec(0,0,0,0,0,0,0,0)};
    vecs[1]  = '{1'b1, 4'b1111, a,              1'b0, 7'd0,  4'b0011, 1'b0, 1'b0, 8'd0, dec(1,10,0,1,11,1,0,0)};
    vecs[2]  = '{1'b1, 4'b1111, a,              1'b0, 7'd0,  4'b1100, 1'b0, 1'b0, 8'd0, dec(1,12,2,1,13,3,0,0)};
    vecs[3]  = '{1'b1, 4'b1111, a,              1'b0, 7'd0,  4'b0011, 1'b0, 1'b0, 8'd0, dec(1,10,0,1,11,1,0,0)};
    vecs[4]  = '{1'b1, 4'b0001, pk(5,0,0,0),    1'b1, 7'd9,  4'b0001, 1'b1, 1'b0, 8'd0, dec(1,5,0,0,0,0,1,9)};
    vecs[5]  = '{1'b1, 4'b1111, a,              1'b1, 7'd20, 4'b0110, 1'b0, 1'b0, 8'd0, dec(1,11,1,1,12,2,0,0)};
    vecs[6]  = '{1'b1, 4'b1111, a,              1'b1, 7'd20, 4'b1001, 1'b0, 1'b0, 8'd1, dec(1,13,3,1,10,0,0,0)};
    vecs[7]  = '{1'b1, 4'b1111, a,              1'b1, 7'd20, 4'b0110, 1'b0, 1'b0, 8'd2, dec(1,11,1,1,12,2,0,0)};
    vecs[8]  = '{1'b1, 4'b1111, a,              1'b1, 7'd20, 4'b1000, 1'b1, 1'b1, 8'd3, dec(1,13,3,0,0,0,1,20)};
    vecs[9]  = '{1'b1, 4'b0001, pk(7,0,0,0),    1'b1, 7'd7,  4'b0001, 1'b0, 1'b0, 8'd0, dec(1,7,0,0,0,0,0,0)};
    vecs[10] = '{1'b1, 4'b0001, pk(7,0,0,0),    1'b1, 7'd7,  4'b0001, 1'b0, 1'b0, 8'd1, dec(1,7,0,0,0,0,0,0)};
    vecs[11] = '{1'b1, 4'b0001, pk(7,0,0,0),    1'b1, 7'd7,  4'b0001, 1'b0, 1'b0, 8'd2, dec(1,7,0,0,0,0,0,0)};
    vecs[12] = '{1'b1, 4'b0001, pk(7,0,0,0),    1'b1, 7'd7,  4'b0000, 1'b1, 1'b1, 8'd3, dec(0,0,0,0,0,0,1,7)};
    vecs[13] = '{1'b1, 4'b1111, a,              1'b1, 7'd20, 4'b0110, 1'b0, 1'b0, 8'd0, dec(1,11,1,1,12,2,0,0)};
    vecs[14] = '{1'b0, 4'b1111, a,              1'b1, 7'd20, 4'b0000, 1'b0, 1'b0, 8'd1, dec(0,0,0,0,0,0,0,0)};
    vecs[15] = '{1'b1, 4'b1111, a,              1'b0, 7'd0,  4'b0011, 1'b0, 1'b0, 8'd0, dec(1,10,0,1,11,1,0,0)};
    vecs[16] = '{1'b1, 4'b0011, pk(30,30,0,0),  1'b0, 7'd0,  4'b0011, 1'b0, 1'b0, 8'd0, dec(1,30,0,1,30,1,0,0)};

    // Outputs after the initial reset must all be zero.
    exp_q.push_back('0);

    for (int v = 0; v < 17; v++) begin
      pop_dec(v);
      drive(vecs[v].rst, vecs[v].rdq, vecs[v].ra, vecs[v].wq, vecs[v].wa);
      #3;
      chk($sformatf("rd_gnt_vec%0d", v), {28'b0, rd_gnt}, {28'b0, vecs[v].eg});
      chk($sformatf("wr_gnt_vec%0d", v), {31'b0, wr_gnt}, {31'b0, vecs[v].ewg});
      chk($sformatf("state_vec%0d", v), {31'b0, dbg_wr_prio}, {31'b0, vecs[v].est});
      chk($sformatf("starve_vec%0d", v), {24'b0, dbg_starve_cnt}, {24'b0, vecs[v].ecnt});
      exp_q.push_back(vecs[v].edec);
      @(posedge clk);
      #1;
    end
    pop_dec(17);

    // Random phase: requesters obey the hold-until-granted rule.
    rst_n   = 1'b1;
    rq      = '0;
    ra      = '0;
    wq      = 1'b0;
    wa      = '0;
    g       = '0;
    wg      = 1'b0;
    refused = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(rq[i] && !g[i])) begin
          rq[i]         = 1'($urandom_range(0, 1));
          ra[i*AW +: AW] = 7'($urandom_range(0, 3));
        end
      end
      if (!(wq && !wg)) begin
        wq = 1'($urandom_range(0, 1));
        wa = 7'($urandom_range(0, 3));
      end
      drive(1'b1, rq, ra, wq, wa);
      #3;
      g  = rd_gnt;
      wg = wr_gnt;
      conflict = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (g[i] && wg && (ra[i*AW +: AW] == wa)) conflict = 1'b1;
      end
      chk("rnd_gnt_subset", {28'b0, g & ~rq}, 32'd0);
      chk("rnd_max_two_reads", {31'b0, ($countones(g) <= 2)}, 32'd1);
      chk("rnd_wr_with_two_reads", {31'b0, (wg && ($countones(g) == 2))}, 32'd0);
      chk("rnd_same_row_conflict", {31'b0, conflict}, 32'd0);
      if (wq && !wg) refused++;
      else refused = 0;
      chk("rnd_starve_bound", {31'b0, (refused > 3)}, 32'd0);
      @(posedge clk);
      #1;
      chk("rnd_no_dropped_write", {31'b0, read_enable1 & read_enable2 & write_enable}, 32'd0);
      chk("rnd_en2_implies_en1", {31'b0, read_enable2 & ~read_enable1}, 32'd0);
      chk("rnd_port1_idle_zero", {31'b0, (!read_enable1 && (read_address1 != 0 || read_src1 != 0))}, 32'd0);
      chk("rnd_port2_idle_zero", {31'b0, (!read_enable2 && (read_address2 != 0 || read_src2 != 0))}, 32'd0);
      chk("rnd_write_enable", {31'b0, write_enable}, {31'b0, wq && wg});
      chk("rnd_write_address", {25'b0, write_address}, {25'b0, (wq && wg) ? wa : 7'd0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
